// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/valid handshake,
// assembles opcode+immediate pairs and loads the IF/ID register feeding decode.
module fetch_stage #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [4:0]          IMM_OPCODE   = 5'b10100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                jump_occured,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    input  logic                imem_valid,
    output logic [15:0]         instruction,
    output logic [15:0]         immediate,
    output logic [PC_WIDTH-1:0] pc_plus1,
    output logic                instr_valid
);

    typedef enum logic {S_OP, S_IMM} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [15:0]         op_buf_q, op_buf_d;
    logic [15:0]         instr_q, instr_d;
    logic [15:0]         imm_q, imm_d;
    logic [PC_WIDTH-1:0] pcp1_q, pcp1_d;
    logic                valid_q, valid_d;
    logic                accept;

    assign imem_req    = reset & ~stall & ~jump_occured;
    assign imem_addr   = pc_q;
    assign accept      = imem_req & imem_valid;
    assign pc_inc      = pc_q + PC_WIDTH'(1);

    assign instruction = instr_q;
    assign immediate   = imm_q;
    assign pc_plus1    = pcp1_q;
    assign instr_valid = valid_q;

    always_comb begin
        // NOTE: every next-state value defaults to "hold" first, so no path can infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        op_buf_d = op_buf_q;
        instr_d  = instr_q;
        imm_d    = imm_q;
        pcp1_d   = pcp1_q;
        valid_d  = valid_q;

        // Redirect beats stall and any returned word; a half-fetched pair is dropped.
        if (jump_occured) begin
            pc_d     = jump_target;
            state_d  = S_OP;
            op_buf_d = '0;
            instr_d  = '0;
            valid_d  = 1'b0;
        end else if (stall) begin
            // everything held, imem_valid ignored
        end else if (accept) begin
            unique case (state_q)
                S_OP: begin
                    pc_d = pc_inc;
                    if (imem_data[15:11] == IMM_OPCODE) begin
                        op_buf_d = imem_data;
                        valid_d  = 1'b0;
                        state_d  = S_IMM;
                    end else begin
                        instr_d = imem_data;
                        pcp1_d  = pc_inc;
                        valid_d = 1'b1;
                    end
                end
                S_IMM: begin
                    instr_d = op_buf_q;
                    imm_d   = imem_data;
                    pc_d    = pc_inc;
                    pcp1_d  = pc_inc;
                    valid_d = 1'b1;
                    state_d = S_OP;
                end
                default: state_d = S_OP;
            endcase
        end else begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_OP;
            pc_q     <= RESET_VECTOR;
            op_buf_q <= '0;
            instr_q  <= '0;
            imm_q    <= '0;
            pcp1_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_buf_q <= op_buf_d;
            instr_q  <= instr_d;
            imm_q    <= imm_d;
            pcp1_q   <= pcp1_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: one record per clock cycle,
// plus hand-written sequences for reset behaviour.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump_occured;
    logic [15:0] jump_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [15:0] instruction;
    logic [15:0] immediate;
    logic [15:0] pc_plus1;
    logic        instr_valid;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .jump_occured (jump_occured),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .imem_valid   (imem_valid),
        .instruction  (instruction),
        .immediate    (immediate),
        .pc_plus1     (pc_plus1),
        .instr_valid  (instr_valid)
    );

    typedef struct {
        logic        rst, stl, jmp;
        logic [15:0] jt;
        logic        vld;
        logic [15:0] data;
        logic        exp_req;      // before the edge
        logic [15:0] exp_addr;     // before the edge
        logic [15:0] exp_instr;    // after the edge
        logic [15:0] exp_imm;
        logic [15:0] exp_pcp1;
        logic        exp_v;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic stl, input logic jmp, input logic [15:0] jt,
                                input logic vld, input logic [15:0] data,
                                input logic exp_req, input logic [15:0] exp_addr,
                                input logic [15:0] exp_instr, input logic [15:0] exp_imm,
                                input logic [15:0] exp_pcp1, input logic exp_v);
        vec_t v;
        v.rst = 1'b1; v.stl = stl; v.jmp = jmp; v.jt = jt; v.vld = vld; v.data = data;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_instr = exp_instr;
        v.exp_imm = exp_imm; v.exp_pcp1 = exp_pcp1; v.exp_v = exp_v;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [15:0] ei, input logic [15:0] em,
                              input logic [15:0] ep, input logic ev);
        check({tag, ".instruction"}, instruction, ei);
        check({tag, ".immediate"},   immediate,   em);
        check({tag, ".pc_plus1"},    pc_plus1,    ep);
        check({tag, ".instr_valid"}, 16'(instr_valid), 16'(ev));
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; jump_occured = 1'b0; jump_target = '0;
        imem_valid = 1'b0; imem_data = '0;

        // stl jmp  jt       vld data     req addr     instr    imm      pcp1     v
        add(0, 0, 16'h0000, 1, 16'h0800, 1, 16'h0000, 16'h0800, 16'h0000, 16'h0001, 1);
        add(0, 0, 16'h0000, 1, 16'h1120, 1, 16'h0001, 16'h1120, 16'h0000, 16'h0002, 1);
        add(0, 0, 16'h0000, 1, 16'h2240, 1, 16'h0002, 16'h2240, 16'h0000, 16'h0003, 1);
        add(0, 0, 16'h0000, 1, 16'h3000, 1, 16'h0003, 16'h3000, 16'h0000, 16'h0004, 1);
        // two-word instruction: one bubble, then the pair
        add(0, 0, 16'h0000, 1, 16'hA100, 1, 16'h0004, 16'h3000, 16'h0000, 16'h0004, 0);
        add(0, 0, 16'h0000, 1, 16'hBEEF, 1, 16'h0005, 16'hA100, 16'hBEEF, 16'h0006, 1);
        add(0, 0, 16'h0000, 1, 16'h4444, 1, 16'h0006, 16'h4444, 16'hBEEF, 16'h0007, 1);
        // three wait states at address 7, word lands on the 4th edge
        add(0, 0, 16'h0000, 0, 16'h5555, 1, 16'h0007, 16'h4444, 16'hBEEF, 16'h0007, 0);
        add(0, 0, 16'h0000, 0, 16'h5555, 1, 16'h0007, 16'h4444, 16'hBEEF, 16'h0007, 0);
        add(0, 0, 16'h0000, 0, 16'h5555, 1, 16'h0007, 16'h4444, 16'hBEEF, 16'h0007, 0);
        add(0, 0, 16'h0000, 1, 16'h5678, 1, 16'h0007, 16'h5678, 16'hBEEF, 16'h0008, 1);
        // stall two cycles: everything frozen, returned word ignored
        add(1, 0, 16'h0000, 1, 16'h9999, 0, 16'h0008, 16'h5678, 16'hBEEF, 16'h0008, 1);
        add(1, 0, 16'h0000, 1, 16'h9999, 0, 16'h0008, 16'h5678, 16'hBEEF, 16'h0008, 1);
        // opcode word accepted, then jump abandons the pair
        add(0, 0, 16'h0000, 1, 16'hA222, 1, 16'h0008, 16'h5678, 16'hBEEF, 16'h0008, 0);
        add(0, 1, 16'h0040, 1, 16'h7777, 0, 16'h0009, 16'h0000, 16'hBEEF, 16'h0008, 0);
        add(0, 0, 16'h0000, 1, 16'h1234, 1, 16'h0040, 16'h1234, 16'hBEEF, 16'h0041, 1);
        // jump and stall together: jump wins
        add(1, 1, 16'h0080, 1, 16'h6666, 0, 16'h0041, 16'h0000, 16'hBEEF, 16'h0041, 0);
        add(0, 0, 16'h0000, 1, 16'h2345, 1, 16'h0080, 16'h2345, 16'hBEEF, 16'h0081, 1);
        // wrap at the top of the address space
        add(0, 1, 16'hFFFF, 1, 16'h6666, 0, 16'h0081, 16'h0000, 16'hBEEF, 16'h0081, 0);
        add(0, 0, 16'h0000, 1, 16'h3456, 1, 16'hFFFF, 16'h3456, 16'hBEEF, 16'h0000, 1);
        add(0, 0, 16'h0000, 1, 16'h0111, 1, 16'h0000, 16'h0111, 16'hBEEF, 16'h0001, 1);
        // opcode word at address 1 -> mid-pair when reset hits below
        add(0, 0, 16'h0000, 1, 16'hA333, 1, 16'h0001, 16'h0111, 16'hBEEF, 16'h0001, 0);

        // held in reset from time zero
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        check("rst0.imem_req", 16'(imem_req), 16'h0000);
        check("rst0.imem_addr", imem_addr, 16'h0000);
        check_regs("rst0", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            @(negedge clk);
            reset        = vecs[i].rst;
            stall        = vecs[i].stl;
            jump_occured = vecs[i].jmp;
            jump_target  = vecs[i].jt;
            imem_valid   = vecs[i].vld;
            imem_data    = vecs[i].data;
            #1;
            check({tag, ".imem_req"},  16'(imem_req), 16'(vecs[i].exp_req));
            check({tag, ".imem_addr"}, imem_addr, vecs[i].exp_addr);
            @(posedge clk);
            #1;
            check_regs(tag, vecs[i].exp_instr, vecs[i].exp_imm, vecs[i].exp_pcp1, vecs[i].exp_v);
            n_vec++;
        end

        // reset mid-S_IMM: takes effect without a clock edge
        @(negedge clk);
        stall = 1'b0; jump_occured = 1'b0; imem_valid = 1'b1; imem_data = 16'hCCCC;
        reset = 1'b0;
        #1;
        n_vec++;
        check("midrst.imem_req", 16'(imem_req), 16'h0000);
        check("midrst.imem_addr", imem_addr, 16'h0000);
        check_regs("midrst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);

        // release: request goes out at the reset vector in the same cycle
        imem_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_vec++;
        check("rel.imem_req", 16'(imem_req), 16'h0001);
        check("rel.imem_addr", imem_addr, 16'h0000);

        // first word after release is decoded as an opcode, not as an immediate
        @(negedge clk);
        imem_valid = 1'b1; imem_data = 16'h0800;
        @(posedge clk);
        #1;
        n_vec++;
        check_regs("relfetch", 16'h0800, 16'h0000, 16'h0001, 1'b1);
        check("relfetch.imem_addr", imem_addr, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
